alarm_ringer: RTL and testbench
===============================

Name: alarm_ringer

Overview:
Consumes the alarm time set by the alarm-setting button block (a_hour/a_min) and the running clock time. Decides when the alarm fires, drives the buzzer and status outputs, and handles stop and snooze requests. Sits between the timekeeping counter, the alarm-setting block, and the buzzer/LED/display outputs.

Parameters:
SNOOZE_MIN, 5, snooze length in minutes; legal range 1..17 so that SNOOZE_MIN*60 fits in 10 bits.
RING_TIMEOUT_S, 60, seconds of unattended ringing before an automatic snooze.
MAX_SNOOZE, 3, maximum snoozes per alarm event; legal range 1..7.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick_1hz  in  1  one-clk-cycle pulse per second
enb  in  1  alarm armed (switch level)
cur_hour  in  6  current hour, 0..23
cur_min  in  6  current minute, 0..59
cur_sec  in  6  current second, 0..59
a_hour  in  6  alarm hour, 0..23
a_min  in  6  alarm minute, 0..59
btn_stop  in  1  stop button, raw level
btn_snooze  in  1  snooze button, raw level
ringing  out  1  high in RINGING
buzzer  out  1  gated beep, 1 Hz on/off pattern
snoozing  out  1  high in SNOOZE
snooze_cnt  out  3  snoozes used in the current event
snooze_left  out  10  seconds remaining in the snooze

Behaviour:
- Reset: all state and outputs are 0; FSM = IDLE. Reset takes effect immediately, including mid-ring or mid-snooze.
- Button inputs: each is rising-edge detected internally (one register per button). stop_p / snooze_p are high for exactly one cycle on the first clk where the input is sampled high after being low.
- Registered outputs: ringing and snoozing are decoded from the state register. All transitions take effect on the clk edge after the causing condition.
- match = (cur_hour==a_hour) && (cur_min==a_min).
- IDLE:
  - When enb && match && cur_sec==0, go to RINGING.
  - On that transition: ring_cnt=0, beep=1, snooze_cnt=0.
- RINGING:
  - stop_p: go to DONE.
  - snooze_p with snooze_cnt<MAX_SNOOZE: go to SNOOZE; snooze_left=SNOOZE_MIN*60; snooze_cnt+1.
  - snooze_p with snooze_cnt==MAX_SNOOZE: ignored, alarm keeps ringing.
  - tick_1hz with no button: beep toggles and ring_cnt+1.
  - When ring_cnt reaches RING_TIMEOUT_S on a tick: behaves as an automatic snooze_p. If the snooze limit is already reached, go to DONE instead.
- SNOOZE:
  - stop_p: go to DONE.
  - snooze_p: ignored.
  - tick_1hz: snooze_left-1.
  - tick_1hz with snooze_left==1: snooze_left=0, go to RINGING, ring_cnt=0, beep=1.
- DONE: when !match, go to IDLE. This prevents re-trigger within the alarm minute.
- enb low in any state: next state is IDLE; ring_cnt, snooze_left, beep and snooze_cnt are cleared. This has priority over everything except rst.
- Priority within a cycle: rst > !enb > stop_p > snooze_p > tick_1hz. Ticks coinciding with a winning button are dropped for counting.
- buzzer = beep when in RINGING, else 0.
- snooze_cnt holds its value in DONE for display and clears on the next trigger from IDLE.
- Changing a_hour/a_min during RINGING or SNOOZE does not abort the event. Only DONE's exit uses match.
- Counters: all are unsigned and saturate at neither end. The FSM guarantees that no counter ever decrements below 0 or exceeds its limit.

Test Plan:
(Simulation uses SNOOZE_MIN=1, RING_TIMEOUT_S=5, MAX_SNOOZE=2; tick every 4 clk.)
1. Trigger: enb=1, alarm 07:30, clock reaches 07:30:00 -> ringing=1 the next clk. buzzer pattern 1,0,1,0 across ticks. snooze_cnt=0.
2. Stop: btn_stop held high for 10 clk while ringing -> exactly one stop_p; DONE, ringing=0. No re-trigger through 07:30:59. IDLE at 07:31:00. Next day's 07:30:00 rings again.
3. Snooze limit: snooze while ringing -> snoozing=1, snooze_left=60, snooze_cnt=1. After 60 ticks, ringing=1. Snooze again -> snooze_cnt=2. After 60 ticks, ringing. Third snooze press is ignored, ringing stays 1.
4. Timeout: no buttons -> after 5 ticks an auto-snooze with snooze_cnt=1, snooze_left=60. At the limit (snooze_cnt=2), the 5th tick goes to DONE with ringing=0.
5. Simultaneous stop+snooze rising in the same clk while ringing -> DONE, snooze_cnt unchanged. A tick in the same clk as snooze_p -> beep not toggled, snooze_left=60.
6. Abort paths: enb dropped mid-SNOOZE -> IDLE next clk, all outputs 0. rst asserted mid-RINGING -> outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - alarm trigger, buzzer gating, stop/snooze/timeout sequencing
// Fires at the alarm minute, rings until stopped, snoozes or times out into an automatic snooze.
module alarm_ringer #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       enb,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [5:0] a_hour,
  input  logic [5:0] a_min,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  output logic       ringing,
  output logic       buzzer,
  output logic       snoozing,
  output logic [2:0] snooze_cnt,
  output logic [9:0] snooze_left
);

  localparam int RCW = $clog2(RING_TIMEOUT_S + 1);
  localparam logic [9:0]     SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);
  localparam logic [2:0]     MAX_CNT     = 3'(MAX_SNOOZE);
  localparam logic [RCW-1:0] RING_LAST   = RCW'(RING_TIMEOUT_S - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t         state;
  logic [RCW-1:0] ring_cnt;
  logic           beep;
  logic           stop_q;
  logic           snooze_q;

  logic stop_p;
  logic snooze_p;
  logic match;
  logic can_snooze;
  logic ring_expired;

  assign stop_p       = btn_stop & ~stop_q;
  assign snooze_p     = btn_snooze & ~snooze_q;
  assign match        = (cur_hour == a_hour) && (cur_min == a_min);
  assign can_snooze   = snooze_cnt < MAX_CNT;
  assign ring_expired = ring_cnt == RING_LAST;

  assign ringing  = (state == RINGING);
  assign snoozing = (state == SNOOZE);
  assign buzzer   = ringing & beep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ring_cnt    <= '0;
      beep        <= 1'b0;
      snooze_cnt  <= 3'd0;
      snooze_left <= 10'd0;
      stop_q      <= 1'b0;
      snooze_q    <= 1'b0;
    end else begin
      stop_q   <= btn_stop;
      snooze_q <= btn_snooze;
      if (!enb) begin
        // Disarming abandons the event outright, whatever phase it is in.
        state       <= IDLE;
        ring_cnt    <= '0;
        beep        <= 1'b0;
        snooze_cnt  <= 3'd0;
        snooze_left <= 10'd0;
      end else begin
        case (state)
          IDLE: begin
            if (match && cur_sec == 6'd0) begin
              state      <= RINGING;
              ring_cnt   <= '0;
              beep       <= 1'b1;
              snooze_cnt <= 3'd0;
            end
          end
          RINGING: begin
            if (stop_p) begin
              state <= DONE;
              beep  <= 1'b0;
            end else if (snooze_p && can_snooze) begin
              state       <= SNOOZE;
              snooze_left <= SNOOZE_LOAD;
              snooze_cnt  <= snooze_cnt + 3'd1;
            end else if (tick_1hz) begin
              // The last ringing second acts as a snooze press, or ends the event once snoozes run out.
              if (ring_expired) begin
                if (can_snooze) begin
                  state       <= SNOOZE;
                  snooze_left <= SNOOZE_LOAD;
                  snooze_cnt  <= snooze_cnt + 3'd1;
                end else begin
                  state <= DONE;
                  beep  <= 1'b0;
                end
              end else begin
                beep     <= ~beep;
                ring_cnt <= ring_cnt + 1'b1;
              end
            end
          end
          SNOOZE: begin
            if (stop_p) begin
              state       <= DONE;
              snooze_left <= 10'd0;
            end else if (tick_1hz) begin
              if (snooze_left == 10'd1) begin
                state       <= RINGING;
                snooze_left <= 10'd0;
                ring_cnt    <= '0;
                beep        <= 1'b1;
              end else begin
                snooze_left <= snooze_left - 10'd1;
              end
            end
          end
          DONE: begin
            // Leaving only after the alarm minute passes keeps it from re-firing.
            if (!match) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_ringer.sv
// tb/tb_alarm_ringer.sv - directed vector table plus multi-cycle sequences for alarm_ringer
module tb_alarm_ringer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz;
  logic       enb;
  logic [5:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [5:0] a_hour;
  logic [5:0] a_min;
  logic       btn_stop;
  logic       btn_snooze;
  logic       ringing;
  logic       buzzer;
  logic       snoozing;
  logic [2:0] snooze_cnt;
  logic [9:0] snooze_left;

  always #5 clk = ~clk;

  alarm_ringer #(
    .SNOOZE_MIN(1),
    .RING_TIMEOUT_S(5),
    .MAX_SNOOZE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick_1hz(tick_1hz),
    .enb(enb),
    .cur_hour(cur_hour),
    .cur_min(cur_min),
    .cur_sec(cur_sec),
    .a_hour(a_hour),
    .a_min(a_min),
    .btn_stop(btn_stop),
    .btn_snooze(btn_snooze),
    .ringing(ringing),
    .buzzer(buzzer),
    .snoozing(snoozing),
    .snooze_cnt(snooze_cnt),
    .snooze_left(snooze_left)
  );

  typedef struct {
    logic       enb;
    logic [5:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       stop;
    logic       snz;
    logic       tick;
    logic       ring;
    logic       buz;
    logic       snzg;
    logic [2:0] cnt;
    logic [9:0] left;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t v(input logic e, input int h, input int m, input int s,
                             input logic st, input logic sn, input logic tk,
                             input logic r, input logic b, input logic z,
                             input int c, input int l);
    vec_t x;
    x.enb = e; x.h = 6'(h); x.m = 6'(m); x.s = 6'(s);
    x.stop = st; x.snz = sn; x.tick = tk;
    x.ring = r; x.buz = b; x.snzg = z; x.cnt = 3'(c); x.left = 10'(l);
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic r, input logic b, input logic z,
                         input int c, input int l);
    chk({tag, ".ringing"}, 32'(ringing), 32'(r));
    chk({tag, ".buzzer"}, 32'(buzzer), 32'(b));
    chk({tag, ".snoozing"}, 32'(snoozing), 32'(z));
    chk({tag, ".snooze_cnt"}, 32'(snooze_cnt), 32'(c));
    chk({tag, ".snooze_left"}, 32'(snooze_left), 32'(l));
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      tick_1hz = 1'b1;
      clk1();
      tick_1hz = 1'b0;
      repeat (3) clk1();
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hour = 6'(h);
    cur_min  = 6'(m);
    cur_sec  = 6'(s);
  endtask

  task automatic press_snooze();
    btn_snooze = 1'b1;
    clk1();
  endtask

  task automatic release_btns();
    btn_snooze = 1'b0;
    btn_stop   = 1'b0;
    clk1();
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; enb = 1'b0;
    btn_stop = 1'b0; btn_snooze = 1'b0;
    a_hour = 6'd7; a_min = 6'd30;
    set_time(7, 29, 59);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    //        enb h  m  s   stp snz tk  ring buz snzg cnt left
    vecs.push_back(v(1, 7, 29, 59, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 7, 30, 0,  0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 7, 30, 1,  0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 7, 30, 1,  0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 7, 30, 2,  0, 0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 7, 30, 3,  0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 7, 30, 3,  1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 7, 30, 4,  1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 7, 30, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 7, 30, 59, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 7, 31, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 7, 30, 0,  0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 7, 30, 1,  1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 7, 31, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 7, 30, 0,  0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 7, 30, 1,  0, 1, 1, 0, 0, 1, 1, 60));
    vecs.push_back(v(1, 7, 30, 2,  0, 1, 1, 0, 0, 1, 1, 59));
    vecs.push_back(v(1, 7, 30, 2,  0, 0, 0, 0, 0, 1, 1, 59));
    vecs.push_back(v(1, 7, 30, 3,  0, 1, 0, 0, 0, 1, 1, 59));
    vecs.push_back(v(0, 7, 30, 3,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 7, 30, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 7, 31, 0,  0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      enb = vecs[i].enb;
      set_time(int'(vecs[i].h), int'(vecs[i].m), int'(vecs[i].s));
      btn_stop = vecs[i].stop;
      btn_snooze = vecs[i].snz;
      tick_1hz = vecs[i].tick;
      clk1();
      chk_all($sformatf("vec%0d", i), vecs[i].ring, vecs[i].buz, vecs[i].snzg,
              int'(vecs[i].cnt), int'(vecs[i].left));
    end
    tick_1hz = 1'b0;

    // Snooze limit: two full snoozes, third press ignored.
    set_time(7, 30, 0);
    clk1();
    chk_all("lim.trigger", 1, 1, 0, 0, 0);
    set_time(7, 30, 1);
    press_snooze();
    chk_all("lim.snz1", 0, 0, 1, 1, 60);
    release_btns();
    do_ticks(59);
    chk_all("lim.snz1_end", 0, 0, 1, 1, 1);
    do_ticks(1);
    chk_all("lim.ring2", 1, 1, 0, 1, 0);
    press_snooze();
    chk_all("lim.snz2", 0, 0, 1, 2, 60);
    release_btns();
    do_ticks(60);
    chk_all("lim.ring3", 1, 1, 0, 2, 0);
    press_snooze();
    chk_all("lim.snz3_ignored", 1, 1, 0, 2, 0);
    release_btns();

    // Timeout with snoozes exhausted ends the event; count is held for display.
    do_ticks(4);
    chk_all("tmo.limit_4", 1, 1, 0, 2, 0);
    do_ticks(1);
    chk_all("tmo.limit_done", 0, 0, 0, 2, 0);
    set_time(7, 31, 0);
    clk1();
    chk_all("tmo.idle_hold", 0, 0, 0, 2, 0);

    // Timeout with snoozes available becomes an automatic snooze.
    set_time(7, 30, 0);
    clk1();
    chk_all("tmo.trigger", 1, 1, 0, 0, 0);
    do_ticks(4);
    chk_all("tmo.tick4", 1, 1, 0, 0, 0);
    do_ticks(1);
    chk_all("tmo.auto_snz", 0, 0, 1, 1, 60);

    // Asynchronous reset in the middle of ringing.
    enb = 1'b0;
    set_time(7, 31, 0);
    clk1();
    chk_all("rst.disarm", 0, 0, 0, 0, 0);
    enb = 1'b1;
    clk1();
    set_time(7, 30, 0);
    clk1();
    chk_all("rst.ring", 1, 1, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    chk_all("rst.async", 0, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    set_time(7, 31, 0);
    clk1();
    chk_all("rst.after", 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
